// File: rtl/issue_ctl.sv
// Dual-issue scheduler between the decode register and the two EX lanes.
// Splits a pair when intra-pair, structural or load-use hazards block dual issue.

package issue_pkg;
    typedef struct packed {
        logic rs1;
        logic rs2;
        logic rd;
        logic lsu;
        logic bru;
    } enable_pkt_t;

    typedef enum logic {
        PAIR = 1'b0,
        TAIL = 1'b1
    } state_t;
endpackage

module issue_ctl
    import issue_pkg::*;
#(
    parameter int LOAD_LAT = 2,
    parameter int SB_W     = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  enable_pkt_t s0_en,
    input  logic [4:0]  s0_rs1,
    input  logic [4:0]  s0_rs2,
    input  logic [4:0]  s0_rd,
    input  enable_pkt_t s1_en,
    input  logic [4:0]  s1_rs1,
    input  logic [4:0]  s1_rs2,
    input  logic [4:0]  s1_rd,
    input  logic        ex_ready,
    output logic        iss0_valid,
    output logic        iss0_slot,
    output logic        iss1_valid
);

    localparam logic [SB_W-1:0] SB_SET = SB_W'(LOAD_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [SB_W-1:0]   sb [32];
    logic [31:0]       busy;
    logic              hz0;
    logic              hz1;
    logic              hz_pair;
    logic              ld_vld;
    logic [4:0]        ld_rd;
    enable_pkt_t       lane0_en;
    logic [4:0]        lane0_rd;
    logic              s1_bru_unused;

    // A slot is blocked if it reads or overwrites a register with a load still in flight.
    function automatic logic hz_sb(input enable_pkt_t en, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [4:0] rd,
                                   input logic [31:0] bsy);
        return (en.rs1 && bsy[rs1]) || (en.rs2 && bsy[rs2]) || (en.rd && bsy[rd]);
    endfunction

    always_comb begin
        busy = '0;
        for (int i = 1; i < 32; i++) busy[i] = (sb[i] != '0);
    end

    assign hz0 = hz_sb(s0_en, s0_rs1, s0_rs2, s0_rd, busy);
    assign hz1 = hz_sb(s1_en, s1_rs1, s1_rs2, s1_rd, busy);

    // Nothing is ever paired behind a branch; slot 1 cannot see slot 0's result in the same cycle.
    assign hz_pair = (s0_en.rd && (s0_rd != 5'd0) &&
                      ((s1_en.rs1 && (s1_rs1 == s0_rd)) || (s1_en.rs2 && (s1_rs2 == s0_rd))))
                   || (s0_en.lsu && s1_en.lsu)
                   || s0_en.bru;

    assign s1_bru_unused = s1_en.bru;

    always_comb begin
        state_nxt  = state;
        iss0_valid = 1'b0;
        iss0_slot  = 1'b0;
        iss1_valid = 1'b0;
        dec_ready  = 1'b0;
        if (flush) begin
            dec_ready = 1'b1;
            state_nxt = PAIR;
        end else if (dec_valid && ex_ready) begin
            case (state)
                PAIR: begin
                    if (!hz0) begin
                        iss0_valid = 1'b1;
                        if (!hz_pair && !hz1) begin
                            iss1_valid = 1'b1;
                            dec_ready  = 1'b1;
                        end else begin
                            state_nxt = TAIL;
                        end
                    end
                end
                TAIL: begin
                    if (!hz1) begin
                        iss0_valid = 1'b1;
                        iss0_slot  = 1'b1;
                        dec_ready  = 1'b1;
                        state_nxt  = PAIR;
                    end
                end
                default: state_nxt = PAIR;
            endcase
        end
    end

    // At most one load issues per cycle, so a single set port covers both lanes.
    assign lane0_en = iss0_slot ? s1_en : s0_en;
    assign lane0_rd = iss0_slot ? s1_rd : s0_rd;

    always_comb begin
        ld_vld = 1'b0;
        ld_rd  = 5'd0;
        if (iss0_valid && lane0_en.lsu && lane0_en.rd && (lane0_rd != 5'd0)) begin
            ld_vld = 1'b1;
            ld_rd  = lane0_rd;
        end else if (iss1_valid && s1_en.lsu && s1_en.rd && (s1_rd != 5'd0)) begin
            ld_vld = 1'b1;
            ld_rd  = s1_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= PAIR;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters keep draining on stalls and flushes; in-flight loads still complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) sb[i] <= '0;
        end else begin
            sb[0] <= '0;
            for (int i = 1; i < 32; i++) begin
                if (ld_vld && (ld_rd == 5'(i))) begin
                    sb[i] <= SB_SET;
                end else if (sb[i] != '0) begin
                    sb[i] <= sb[i] - SB_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_ctl.sv
// Scoreboard bench for issue_ctl: two instances (LOAD_LAT=2 and 3) share one stimulus
// stream; expected output vectors are queued per cycle and compared on the falling edge.
module tb_issue_ctl;
    import issue_pkg::*;

    localparam logic [3:0] DUAL = 4'b1011;  // {iss0_valid, iss0_slot, iss1_valid, dec_ready}
    localparam logic [3:0] S0   = 4'b1000;
    localparam logic [3:0] S1   = 4'b1101;
    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] DROP = 4'b0001;

    typedef struct {
        string      tag;
        logic [3:0] w2;
        logic [3:0] w3;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        dec_valid = 1'b0;
    logic        ex_ready = 1'b1;
    enable_pkt_t s0_en = '0;
    enable_pkt_t s1_en = '0;
    logic [4:0]  s0_rs1 = '0, s0_rs2 = '0, s0_rd = '0;
    logic [4:0]  s1_rs1 = '0, s1_rs2 = '0, s1_rd = '0;

    logic a_rdy, a_v0, a_sl, a_v1;
    logic b_rdy, b_v0, b_sl, b_v1;

    exp_t exp_q[$];
    exp_t ent;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    issue_ctl #(.LOAD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .dec_valid(dec_valid), .dec_ready(a_rdy),
        .s0_en(s0_en), .s0_rs1(s0_rs1), .s0_rs2(s0_rs2), .s0_rd(s0_rd),
        .s1_en(s1_en), .s1_rs1(s1_rs1), .s1_rs2(s1_rs2), .s1_rd(s1_rd),
        .ex_ready(ex_ready), .iss0_valid(a_v0), .iss0_slot(a_sl), .iss1_valid(a_v1)
    );

    issue_ctl #(.LOAD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .dec_valid(dec_valid), .dec_ready(b_rdy),
        .s0_en(s0_en), .s0_rs1(s0_rs1), .s0_rs2(s0_rs2), .s0_rd(s0_rd),
        .s1_en(s1_en), .s1_rs1(s1_rs1), .s1_rs2(s1_rs2), .s1_rd(s1_rd),
        .ex_ready(ex_ready), .iss0_valid(b_v0), .iss0_slot(b_sl), .iss1_valid(b_v1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            ent = exp_q.pop_front();
            check({ent.tag, "/L2"}, {28'd0, a_v0, a_sl, a_v1, a_rdy}, {28'd0, ent.w2});
            check({ent.tag, "/L3"}, {28'd0, b_v0, b_sl, b_v1, b_rdy}, {28'd0, ent.w3});
        end
    end

    function automatic enable_pkt_t mk(input logic r1, input logic r2, input logic rd,
                                       input logic lsu, input logic bru);
        enable_pkt_t e;
        e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.lsu = lsu; e.bru = bru;
        return e;
    endfunction

    task automatic pair(input enable_pkt_t e0, input logic [4:0] a0, input logic [4:0] b0,
                        input logic [4:0] d0, input enable_pkt_t e1, input logic [4:0] a1,
                        input logic [4:0] b1, input logic [4:0] d1);
        dec_valid = 1'b1;
        s0_en = e0; s0_rs1 = a0; s0_rs2 = b0; s0_rd = d0;
        s1_en = e1; s1_rs1 = a1; s1_rs2 = b1; s1_rd = d1;
    endtask

    task automatic cyc(input string tag, input logic [3:0] w2, input logic [3:0] w3);
        exp_t e;
        e.tag = tag; e.w2 = w2; e.w3 = w3;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dec_valid = 1'b0;
        s0_en = '0;
        s1_en = '0;
        for (int i = 0; i < n; i++) cyc("idle", NONE, NONE);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_state2", dut2.state, PAIR);
        check("rst_state3", dut3.state, PAIR);
        check("rst_out", {a_v0, a_sl, a_v1, a_rdy}, NONE);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // independent ALU pair dual-issues
        pair(mk(1, 1, 1, 0, 0), 5'd2, 5'd3, 5'd1, mk(1, 1, 1, 0, 0), 5'd5, 5'd6, 5'd4);
        cyc("add_sub", DUAL, DUAL);
        check("add_sub_state", dut2.state, PAIR);

        // intra-pair RAW splits; same pair through x0 does not
        pair(mk(1, 0, 1, 0, 0), 5'd0, 5'd0, 5'd5, mk(1, 1, 1, 0, 0), 5'd5, 5'd5, 5'd6);
        cyc("raw_c0", S0, S0);
        check("raw_tail", dut2.state, TAIL);
        cyc("raw_c1", S1, S1);
        pair(mk(1, 0, 1, 0, 0), 5'd0, 5'd0, 5'd0, mk(1, 1, 1, 0, 0), 5'd0, 5'd0, 5'd6);
        cyc("raw_x0", DUAL, DUAL);

        // two memory ops, then branch in slot 0
        pair(mk(1, 0, 1, 1, 0), 5'd1, 5'd0, 5'd7, mk(1, 1, 0, 1, 0), 5'd3, 5'd2, 5'd0);
        cyc("lsu_c0", S0, S0);
        cyc("lsu_c1", S1, S1);
        idle(3);
        pair(mk(1, 1, 0, 0, 1), 5'd1, 5'd2, 5'd0, mk(1, 1, 1, 0, 0), 5'd5, 5'd6, 5'd4);
        cyc("bru_c0", S0, S0);
        cyc("bru_c1", S1, S1);

        // load-use: dependent issues at t+2 (L2) / t+3 (L3)
        pair(mk(1, 0, 1, 1, 0), 5'd1, 5'd0, 5'd8, '0, 5'd0, 5'd0, 5'd0);
        cyc("lu_load", DUAL, DUAL);
        check("lu_sb2", dut2.sb[8], 1);
        pair(mk(1, 1, 1, 0, 0), 5'd8, 5'd1, 5'd9, '0, 5'd0, 5'd0, 5'd0);
        cyc("lu_t1", NONE, NONE);
        cyc("lu_t2", DUAL, NONE);
        cyc("lu_t3", DUAL, DUAL);
        idle(3);

        // WAW against the pending load stalls the same way
        pair(mk(1, 0, 1, 1, 0), 5'd1, 5'd0, 5'd8, '0, 5'd0, 5'd0, 5'd0);
        cyc("waw_load", DUAL, DUAL);
        pair(mk(1, 0, 1, 0, 0), 5'd1, 5'd0, 5'd8, '0, 5'd0, 5'd0, 5'd0);
        cyc("waw_t1", NONE, NONE);
        cyc("waw_t2", DUAL, NONE);
        cyc("waw_t3", DUAL, DUAL);
        idle(3);

        // EX back-pressure in TAIL while the scoreboard drains
        pair(mk(1, 0, 1, 1, 0), 5'd1, 5'd0, 5'd8, mk(1, 1, 1, 0, 0), 5'd8, 5'd8, 5'd10);
        cyc("bp_c0", S0, S0);
        check("bp_sb_a", dut3.sb[8], 2);
        ex_ready = 1'b0;
        cyc("bp_h1", NONE, NONE);
        check("bp_sb_b", dut3.sb[8], 1);
        cyc("bp_h2", NONE, NONE);
        check("bp_sb_c", dut3.sb[8], 0);
        cyc("bp_h3", NONE, NONE);
        check("bp_state", dut3.state, TAIL);
        ex_ready = 1'b1;
        cyc("bp_rel", S1, S1);
        check("bp_pair", dut3.state, PAIR);
        idle(3);

        // flush in TAIL with x3 pending
        pair(mk(1, 0, 1, 1, 0), 5'd1, 5'd0, 5'd3, mk(1, 1, 1, 0, 0), 5'd3, 5'd0, 5'd4);
        cyc("fl_c0", S0, S0);
        check("fl_sb_pre", dut2.sb[3], 1);
        flush = 1'b1;
        cyc("fl_drop", DROP, DROP);
        flush = 1'b0;
        check("fl_state2", dut2.state, PAIR);
        check("fl_state3", dut3.state, PAIR);
        check("fl_sb2", dut2.sb[3], 0);
        check("fl_sb3", dut3.sb[3], 1);
        idle(3);

        // asynchronous reset in the middle of a split
        pair(mk(1, 0, 1, 1, 0), 5'd1, 5'd0, 5'd3, mk(1, 1, 1, 0, 0), 5'd3, 5'd0, 5'd4);
        cyc("rs_c0", S0, S0);
        #2 rst_n = 1'b0;
        #1;
        check("rs_state2", dut2.state, PAIR);
        check("rs_state3", dut3.state, PAIR);
        check("rs_sb2", dut2.sb[3], 0);
        check("rs_sb3", dut3.sb[3], 0);
        check("rs_out", {a_v0, a_sl, a_v1, a_rdy}, S0);
        dec_valid = 1'b0;
        #1;
        check("rs_out_idle", {b_v0, b_sl, b_v1, b_rdy}, NONE);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        pair(mk(1, 1, 1, 0, 0), 5'd2, 5'd3, 5'd1, mk(1, 1, 1, 0, 0), 5'd5, 5'd6, 5'd4);
        cyc("rs_recover", DUAL, DUAL);
        idle(1);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
